sha3_core_arbiter: RTL and testbench
====================================

Name: sha3_core_arbiter

Overview:
- Shares one SHA3TOP sponge core (1088-bit rate blocks, `more`/`in_valid`/`hash_next`/`out_valid` handshake) among NUM_REQ requesters, e.g. the HMAC engine plus a plain SHA3-256 hash port.
- Grants the core for a whole multi-block message.
- Routes the core's handshake signals only to the current owner.
- Arbitration is round-robin.

Parameters:
NUM_REQ, 2, number of requesters (2..4)
IDX_W, 1, width of the grant index; must equal ceil(log2(NUM_REQ)), minimum 1
BLK_CNT_W, 8, width of the per-message block counter

Ports:
clk  input  1  clock
rst_n  input  1  reset; asynchronous, active-low
req  input  NUM_REQ  per-requester request; held high for the whole message
req_in  input  NUM_REQ*1088  per-requester block data; requester k occupies bits [k*1088 +: 1088]
req_more  input  NUM_REQ  per-requester `more` flag (1 = further blocks follow)
req_in_valid  input  NUM_REQ  per-requester block strobe (1-cycle pulse)
gnt  output  NUM_REQ  one-hot grant, registered
req_hash_next  output  NUM_REQ  core hash_next routed to the owner only
req_out_valid  output  NUM_REQ  core out_valid routed to the owner only
req_out  output  256  core digest, broadcast; valid only with req_out_valid
core_in  output  1088  to SHA3TOP in
core_more  output  1  to SHA3TOP more
core_in_valid  output  1  to SHA3TOP in_valid
core_out  input  256  from SHA3TOP out
core_hash_next  input  1  from SHA3TOP hash_next
core_out_valid  input  1  from SHA3TOP out_valid
busy  output  1  core owned (state BUSY)
blk_cnt  output  BLK_CNT_W  blocks forwarded in the current or last message

Behaviour:
Reset (rst_n low, asynchronous):
- gnt=0, busy=0, blk_cnt=0, state=IDLE, last_idx=NUM_REQ-1, started=0.
- All routed outputs are 0 because gnt=0.

States:
- IDLE
  - If req != 0, select the first set req bit searching from last_idx+1 upward, wrapping modulo NUM_REQ.
  - Next edge: gnt=onehot(sel), last_idx=sel, busy=1, blk_cnt=0, started=0, state->BUSY.
  - Grant latency: 1 cycle after req is sampled.
- BUSY
  - Combinational forwarding from owner g: core_in=req_in[g], core_more=req_more[g], core_in_valid=req_in_valid[g].
  - Return paths: req_hash_next[g]=core_hash_next, req_out_valid[g]=core_out_valid. All non-owner bits are 0.
  - In BUSY and IDLE, req_in_valid from non-owners is ignored; no queuing.
  - Each forwarded in_valid: blk_cnt+1 (saturates at all-ones); started=1.
  - core_out_valid=1: next edge gnt=0, busy=0, state->IDLE; blk_cnt holds its value.
  - Owner drops req while started=0: release next edge, same as completion.
  - Owner drops req while started=1: ignored. The grant is held until core_out_valid, because the core cannot be aborted.

Outside BUSY:
- core_in_valid=0, core_in=0, core_more=0.
- req_out = core_out at all times.

Timing and boundary conditions:
- Back-to-back: out_valid at cycle T -> gnt=0 at T+1 -> next grant at T+2 at the earliest. The core therefore never sees an in_valid of a new owner in the out_valid cycle.
- Simultaneous req with last_idx=0: requester 1 wins, then 0. Fairness: no requester waits more than NUM_REQ-1 messages.
- Non-owner in_valid in the same cycle as owner in_valid: only the owner's is forwarded.
- core_out_valid while IDLE (spurious): ignored, no routing.
- Reset mid-message: grant dropped immediately. SHA3TOP shares rst_n, so both restart clean.

Test Plan:
- Reset, then req=2'b01. Expect gnt=01 one cycle later, busy=1. Requester 0 sends 2 blocks (more=1,0); core hash_next and out_valid are routed only to bit 0. Release 1 cycle after out_valid; blk_cnt=2.
- req=2'b11 held after reset (last_idx=1). Expect order: req0 granted first, then req1 at out_valid+2 cycles. Repeat 4 messages and check alternation 0,1,0,1.
- While req0 owns the core, pulse req_in_valid[1] with req_in=all-ones. Expect core_in_valid to follow req0 only, core_in never all-ones, and blk_cnt unchanged by the pulse.
- Owner drops req before any in_valid. Expect gnt=0 next cycle and blk_cnt=0. Owner drops req after 1 block. Expect gnt held until core_out_valid.
- Assert rst_n=0 mid-message, 1 block in. Expect gnt=0, busy=0, blk_cnt=0 asynchronously; after reset the grant goes to req0 again (last_idx=1).
- HMAC integration: ipad-block / message / opad-block / digest-block sequence through the arbiter, while a second requester hashes "abc" (padded single block). Expect the standard SHA3-256 "abc" digest 3a985da7…11431532, and the HMAC result equal to the result with no contention.

Source files
------------

// File: rtl/sha3_core_arbiter_if.sv
// Requester and SHA3 core handshake bundle for sha3_core_arbiter.
// master: arbiter side; slave: requesters plus the sponge core.
interface sha3_core_arbiter_if #(
  parameter int NUM_REQ   = 2,
  parameter int BLK_CNT_W = 8
);
  logic [NUM_REQ-1:0]      req;
  logic [NUM_REQ*1088-1:0] req_in;
  logic [NUM_REQ-1:0]      req_more;
  logic [NUM_REQ-1:0]      req_in_valid;
  logic [NUM_REQ-1:0]      gnt;
  logic [NUM_REQ-1:0]      req_hash_next;
  logic [NUM_REQ-1:0]      req_out_valid;
  logic [255:0]            req_out;
  logic [1087:0]           core_in;
  logic                    core_more;
  logic                    core_in_valid;
  logic [255:0]            core_out;
  logic                    core_hash_next;
  logic                    core_out_valid;
  logic                    busy;
  logic [BLK_CNT_W-1:0]    blk_cnt;

  modport master (
    input  req,
    input  req_in,
    input  req_more,
    input  req_in_valid,
    input  core_out,
    input  core_hash_next,
    input  core_out_valid,
    output gnt,
    output req_hash_next,
    output req_out_valid,
    output req_out,
    output core_in,
    output core_more,
    output core_in_valid,
    output busy,
    output blk_cnt
  );

  modport slave (
    output req,
    output req_in,
    output req_more,
    output req_in_valid,
    output core_out,
    output core_hash_next,
    output core_out_valid,
    input  gnt,
    input  req_hash_next,
    input  req_out_valid,
    input  req_out,
    input  core_in,
    input  core_more,
    input  core_in_valid,
    input  busy,
    input  blk_cnt
  );
endinterface

// File: rtl/sha3_core_arbiter.sv
// Round-robin arbiter sharing one SHA3 sponge core among NUM_REQ
// requesters; the core is held by one owner for a whole message.
module sha3_core_arbiter #(
  parameter int NUM_REQ   = 2,
  parameter int IDX_W     = 1,
  parameter int BLK_CNT_W = 8
) (
  input logic clk,
  input logic rst_n,
  sha3_core_arbiter_if.master bus
);
  localparam int BLK_W = 1088;

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   gnt_q, gnt_d;
  logic [IDX_W-1:0]     last_q, last_d;
  logic                 started_q, started_d;
  logic [BLK_CNT_W-1:0] cnt_q, cnt_d;

  logic [IDX_W-1:0] sel;
  logic             sel_ok;
  logic [BLK_W-1:0] own_in;
  logic             own_more;
  logic             own_iv;
  logic             own_req;
  logic             busy;
  logic             fwd;

  assign busy = (state_q == BUSY);
  assign fwd  = busy & own_iv;

  // first request after the previous owner, wrapping
  always_comb begin
    int c;
    logic [IDX_W-1:0] ci;
    c      = 0;
    ci     = '0;
    sel    = '0;
    sel_ok = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      c = int'(last_q) + i;
      if (c >= NUM_REQ) c = c - NUM_REQ;
      ci = IDX_W'(c);
      if (!sel_ok && bus.req[ci]) begin
        sel    = ci;
        sel_ok = 1'b1;
      end
    end
  end

  // last_q doubles as the owner index while BUSY
  always_comb begin
    own_in   = '0;
    own_more = 1'b0;
    own_iv   = 1'b0;
    own_req  = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (IDX_W'(k) == last_q) begin
        own_in   = bus.req_in[k*BLK_W +: BLK_W];
        own_more = bus.req_more[k];
        own_iv   = bus.req_in_valid[k];
        own_req  = bus.req[k];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    started_d = started_q;
    cnt_d     = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sel_ok) begin
          state_d   = BUSY;
          gnt_d     = NUM_REQ'(1) << sel;
          last_d    = sel;
          started_d = 1'b0;
          cnt_d     = '0;
        end
      end
      BUSY: begin
        if (fwd) begin
          started_d = 1'b1;
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
        // once a block is in the core it cannot be aborted
        if (bus.core_out_valid ||
            (!own_req && !started_q && !fwd)) begin
          state_d = IDLE;
          gnt_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      last_q    <= IDX_W'(NUM_REQ - 1);
      started_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      started_q <= started_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.gnt           = gnt_q;
  assign bus.busy          = busy;
  assign bus.blk_cnt       = cnt_q;
  assign bus.core_in       = busy ? own_in : '0;
  assign bus.core_more     = busy & own_more;
  assign bus.core_in_valid = fwd;
  assign bus.req_hash_next = gnt_q & {NUM_REQ{bus.core_hash_next}};
  assign bus.req_out_valid = gnt_q & {NUM_REQ{bus.core_out_valid}};
  assign bus.req_out       = bus.core_out;

endmodule

// File: tb/tb_sha3_core_arbiter.sv
// Directed bench for sha3_core_arbiter with a behavioural stand-in
// for the sponge core.
module tb_sha3_core_arbiter;
  localparam int BW = 1088;
  localparam logic [BW-1:0] ABC_BLK =
    {8'h80, {131{8'h00}}, 8'h06, 8'h63, 8'h62, 8'h61};
  localparam logic [255:0] ABC_DIG =
    256'h3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   nchk = 0;
  int   nerr = 0;

  always #5 clk = ~clk;

  sha3_core_arbiter_if #(.NUM_REQ(2), .BLK_CNT_W(8)) bus ();

  sha3_core_arbiter #(
    .NUM_REQ(2),
    .IDX_W(1),
    .BLK_CNT_W(8)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
  );

  task automatic check(input string tag,
                       input logic [255:0] obs,
                       input logic [255:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] fold(input logic [255:0] a,
                                        input logic [BW-1:0] b);
    return {a[254:0], a[255]} ^ b[255:0] ^ b[BW-1:BW-256];
  endfunction

  // core stand-in: hash_next 2 cycles after a non-final block,
  // out_valid 3 cycles after the final block
  logic         c_hn, c_ov, man_ov;
  logic [255:0] c_out, acc, pend;
  int           hn_d, ov_d, nblk;

  assign bus.core_hash_next = c_hn;
  assign bus.core_out_valid = c_ov | man_ov;
  assign bus.core_out       = c_out;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_hn <= 1'b0; c_ov <= 1'b0; c_out <= '0;
      acc <= '0; pend <= '0;
      hn_d <= 0; ov_d <= 0; nblk <= 0;
    end else begin
      c_hn <= 1'b0;
      c_ov <= 1'b0;
      if (hn_d > 0) begin
        hn_d <= hn_d - 1;
        c_hn <= (hn_d == 1);
      end
      if (ov_d > 0) begin
        ov_d <= ov_d - 1;
        if (ov_d == 1) begin
          c_ov <= 1'b1;
          c_out <= pend;
          acc <= '0;
          nblk <= 0;
        end
      end
      if (bus.core_in_valid) begin
        acc  <= fold(acc, bus.core_in);
        nblk <= nblk + 1;
        if (bus.core_more) hn_d <= 2;
        else begin
          ov_d <= 3;
          pend <= (nblk == 0 && bus.core_in == ABC_BLK) ?
                  ABC_DIG : fold(acc, bus.core_in);
        end
      end
    end
  end

  int order[$];
  logic [1:0] gprev = '0;
  always @(negedge clk) begin
    if (bus.gnt != 2'b00 && gprev == 2'b00)
      order.push_back(bus.gnt[1] ? 1 : 0);
    gprev <= bus.gnt;
  end

  task automatic run_msg(input int k, input int n,
                         input logic [BW-1:0] b0,
                         input logic [BW-1:0] b1,
                         input bit intr,
                         output logic [255:0] dig);
    int t;
    logic ki, oi;
    logic [1:0] m;
    logic [BW-1:0] b;
    ki = k[0];
    oi = ~ki;
    m = 2'b01 << k;
    dig = '0;
    @(negedge clk);
    bus.req[ki] = 1'b1;
    t = 0;
    while (!bus.gnt[ki] && t < 400) begin
      @(negedge clk);
      t++;
    end
    check("gnt_wait", bus.gnt, m);
    if (intr) begin
      bus.req_in[int'(oi)*BW +: BW] = '1;
      bus.req_in_valid[oi] = 1'b1;
      #1;
      check("intr_alone", bus.core_in_valid, 0);
      @(negedge clk);
      bus.req_in_valid[oi] = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      b = (i == 0) ? b0 : b1;
      bus.req_in[int'(ki)*BW +: BW] = b;
      bus.req_more[ki] = (i < n - 1);
      bus.req_in_valid[ki] = 1'b1;
      if (intr) bus.req_in_valid[oi] = 1'b1;
      #1;
      check("fwd_valid", bus.core_in_valid, 1);
      check("fwd_data", bus.core_in == b, 1);
      @(negedge clk);
      bus.req_in_valid[ki] = 1'b0;
      if (intr) bus.req_in_valid[oi] = 1'b0;
      if (i < n - 1) begin
        t = 0;
        while (!bus.req_hash_next[ki] && t < 20) begin
          @(negedge clk);
          t++;
        end
        check("hn_route", bus.req_hash_next, m);
      end
    end
    t = 0;
    while (!bus.req_out_valid[ki] && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("ov_route", bus.req_out_valid, m);
    check("blk_cnt_msg", bus.blk_cnt, n);
    dig = bus.req_out;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [BW-1:0] b0, b1, ipad, opad, msg;
    logic [255:0] d, inner, h1, h2, abc, exp_d, inner_e, hm_e;
    int base, t;
    int exp_ord[4];
    exp_ord = '{0, 1, 0, 1};
    b0 = {34{32'hA5A5_0001}};
    b1 = {34{32'h0F1E_2D3C}};
    ipad = {136{8'h36}};
    opad = {136{8'h5c}};
    msg = {34{32'h1234_5678}};
    exp_d = fold(fold('0, b0), b1);
    inner_e = fold(fold('0, ipad), msg);
    hm_e = fold(fold('0, opad), BW'(inner_e));
    bus.req = '0;
    bus.req_in = '0;
    bus.req_more = '0;
    bus.req_in_valid = '0;
    man_ov = 1'b0;

    repeat (2) @(negedge clk);
    check("rst_gnt", bus.gnt, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_cnt", bus.blk_cnt, 0);
    check("rst_civ", bus.core_in_valid, 0);
    rst_n = 1'b1;

    // spurious out_valid while idle
    @(negedge clk);
    man_ov = 1'b1;
    #1;
    check("spur_ov", bus.req_out_valid, 0);
    check("spur_out", bus.req_out, c_out);
    @(negedge clk);
    man_ov = 1'b0;
    check("spur_gnt", bus.gnt, 0);

    // single owner, two blocks
    run_msg(0, 2, b0, b1, 1'b0, d);
    bus.req[0] = 1'b0;
    check("t1_dig", d, exp_d);
    @(negedge clk);
    check("t1_rel", bus.gnt, 0);
    check("t1_busy", bus.busy, 0);
    check("t1_cnt", bus.blk_cnt, 2);

    // both requesting: alternation 0,1,0,1
    do_reset();
    base = order.size();
    fork
      begin
        run_msg(0, 1, b0, b1, 1'b0, d);
        run_msg(0, 1, b1, b0, 1'b0, d);
        bus.req[0] = 1'b0;
      end
      begin
        run_msg(1, 2, b0, b1, 1'b0, d);
        run_msg(1, 1, b0, b1, 1'b0, d);
        bus.req[1] = 1'b0;
      end
    join
    check("ord_n", order.size() - base, 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("ord%0d", i), order[base+i], exp_ord[i]);
    repeat (2) @(negedge clk);

    // non-owner in_valid pulses
    run_msg(0, 2, b0, b1, 1'b1, d);
    bus.req[0] = 1'b0;
    check("t3_dig", d, exp_d);
    repeat (2) @(negedge clk);

    // drop before any block
    bus.req[0] = 1'b1;
    t = 0;
    while (!bus.gnt[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("t4a_gnt", bus.gnt, 2'b01);
    bus.req[0] = 1'b0;
    @(negedge clk);
    check("t4a_rel", bus.gnt, 0);
    check("t4a_cnt", bus.blk_cnt, 0);

    // drop after one block: grant held
    bus.req[0] = 1'b1;
    t = 0;
    while (!bus.gnt[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    bus.req_in[BW-1:0] = b0;
    bus.req_more[0] = 1'b1;
    bus.req_in_valid[0] = 1'b1;
    @(negedge clk);
    bus.req_in_valid[0] = 1'b0;
    bus.req[0] = 1'b0;
    repeat (3) @(negedge clk);
    check("t4b_hold", bus.gnt, 2'b01);
    check("t4b_busy", bus.busy, 1);
    bus.req_in[BW-1:0] = b1;
    bus.req_more[0] = 1'b0;
    bus.req_in_valid[0] = 1'b1;
    @(negedge clk);
    bus.req_in_valid[0] = 1'b0;
    t = 0;
    while (!bus.req_out_valid[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("t4b_ov", bus.req_out_valid, 2'b01);
    check("t4b_gnt_at_ov", bus.gnt, 2'b01);
    @(negedge clk);
    check("t4b_rel", bus.gnt, 0);
    check("t4b_cnt", bus.blk_cnt, 2);

    // reset mid-message
    bus.req[0] = 1'b1;
    t = 0;
    while (!bus.gnt[0] && t < 20) begin
      @(negedge clk);
      t++;
    end
    bus.req_in[BW-1:0] = b0;
    bus.req_more[0] = 1'b1;
    bus.req_in_valid[0] = 1'b1;
    @(negedge clk);
    bus.req_in_valid[0] = 1'b0;
    check("t5_cnt1", bus.blk_cnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_gnt", bus.gnt, 0);
    check("t5_busy", bus.busy, 0);
    check("t5_cnt", bus.blk_cnt, 0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.req = 2'b11;
    @(negedge clk);
    check("t5_regnt", bus.gnt, 2'b01);
    bus.req = 2'b00;
    repeat (3) @(negedge clk);

    // HMAC alone, then against an "abc" hash
    run_msg(0, 2, ipad, msg, 1'b0, inner);
    run_msg(0, 2, opad, BW'(inner), 1'b0, h1);
    bus.req[0] = 1'b0;
    check("hmac_alone", h1, hm_e);
    repeat (2) @(negedge clk);
    h2 = '0;
    abc = '0;
    fork
      begin
        run_msg(0, 2, ipad, msg, 1'b0, inner);
        run_msg(0, 2, opad, BW'(inner), 1'b0, h2);
        bus.req[0] = 1'b0;
      end
      begin
        run_msg(1, 1, ABC_BLK, '0, 1'b0, abc);
        bus.req[1] = 1'b0;
      end
    join
    check("hmac_cont", h2, h1);
    check("abc_dig", abc, ABC_DIG);
    repeat (2) @(negedge clk);
    check("end_idle", bus.busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
